// File: rtl/lsu_byte_sequencer_pkg.sv
// Shared types and helpers for the byte-wide load/store sequencer and the
// data memory port it drives.
package lsu_byte_sequencer_pkg;

  // Sequencer phases: wait for a request, walk the bytes, report completion.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } lsu_state_t;

  // Access size encodings carried in funct3[1:0]; 2'b11 is illegal.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // One byte transaction as presented to the data memory.
  typedef struct packed {
    logic        Valid;
    logic        Wen;
    logic [31:0] Addr;
    logic [7:0]  ByteData;
  } mem_req_t;

  // True for the three encodable access sizes.
  function automatic logic size_legal(input logic [1:0] sz);
    return (sz != 2'b11);
  endfunction

  // Index of the final byte of an access (N-1).
  function automatic logic [1:0] size_last_idx(input logic [1:0] sz);
    logic [1:0] idx;
    case (sz)
      SZ_B:    idx = 2'd0;
      SZ_H:    idx = 2'd1;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/lsu_byte_sequencer_if.sv
// Byte-wide data memory channel: the sequencer is the master that raises
// a request, the memory is the slave that answers with ready and a byte.
interface lsu_byte_sequencer_if;
  logic        MemValid_o;
  logic        MemWen_o;
  logic [31:0] MemAddr_o;
  logic [7:0]  MemByte_o;
  logic        MemReady_i;
  logic [7:0]  MemByte_i;

  modport master (
    output MemValid_o,
    output MemWen_o,
    output MemAddr_o,
    output MemByte_o,
    input  MemReady_i,
    input  MemByte_i
  );

  modport slave (
    input  MemValid_o,
    input  MemWen_o,
    input  MemAddr_o,
    input  MemByte_o,
    output MemReady_i,
    output MemByte_i
  );
endinterface

// File: rtl/lsu_byte_sequencer_extend.sv
// Size and sign/zero extension of an assembled little-endian load word.
module lsu_extend
  import lsu_byte_sequencer_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [31:0] word_o
);

  // Replicate the top bit of the loaded field, or zeros for unsigned loads.
  always_comb begin
    word_o = word_i;
    case (size_i)
      SZ_B:    word_o = uns_i ? {24'd0, word_i[7:0]}
                              : {{24{word_i[7]}}, word_i[7:0]};
      SZ_H:    word_o = uns_i ? {16'd0, word_i[15:0]}
                              : {{16{word_i[15]}}, word_i[15:0]};
      default: word_o = word_i;
    endcase
  end

endmodule

// File: rtl/lsu_byte_sequencer.sv
// Splits one pipeline load/store into sequential single-byte memory
// transactions, assembles read bytes little-endian, extends the result and
// holds the pipeline stalled until the access finishes or times out.
module lsu_byte_sequencer
  import lsu_byte_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int TW      = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Req_i,
  input  logic        Wen_i,
  input  logic [31:0] Addr_i,
  input  logic [31:0] WData_i,
  input  logic [2:0]  funct3_i,
  output logic        Stall_o,
  output logic        Done_o,
  output logic        Err_o,
  output logic [31:0] RData_o,
  lsu_byte_sequencer_if.master mem
);

  lsu_state_t  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0] asm_q, asm_d;
  logic        wen_q, wen_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  mem_req_t    mem_req_q, mem_req_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic        capture;
  logic [1:0]  cnt_inc;
  logic [31:0] asm_merged;
  logic [31:0] ext_word;

  // A load byte is captured only in the cycle the memory signals ready.
  assign capture = (state_q == ACCESS) && mem.MemReady_i && !wen_q;
  assign cnt_inc = cnt_q + 2'd1;

  // Merge the incoming byte into its lane so the final byte can be extended
  // in the same cycle it arrives.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign asm_merged[8*gi +: 8] = (capture && (cnt_q == 2'(gi)))
                                     ? mem.MemByte_i : asm_q[8*gi +: 8];
    end
  endgenerate

  lsu_extend u_extend (
    .word_i (asm_merged),
    .size_i (size_q),
    .uns_i  (uns_q),
    .word_o (ext_word)
  );

  // Next-state logic for the FSM, counters, latches and registered outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    asm_d     = asm_q;
    wen_d     = wen_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    uns_d     = uns_q;
    mem_req_d = mem_req_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    rdata_d   = 32'd0;

    case (state_q)
      IDLE: begin
        mem_req_d = '0;
        if (Req_i) begin
          if (size_legal(funct3_i[1:0])) begin
            wen_d     = Wen_i;
            addr_d    = Addr_i;
            wdata_d   = WData_i;
            size_d    = funct3_i[1:0];
            uns_d     = funct3_i[2];
            cnt_d     = 2'd0;
            tmo_d     = '0;
            asm_d     = 32'd0;
            mem_req_d = '{Valid: 1'b1, Wen: Wen_i, Addr: Addr_i,
                          ByteData: WData_i[7:0]};
            state_d   = ACCESS;
          end else begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end

      ACCESS: begin
        if (mem.MemReady_i) begin
          asm_d = asm_merged;
          tmo_d = '0;
          if (cnt_q == size_last_idx(size_q)) begin
            mem_req_d = '0;
            done_d    = 1'b1;
            rdata_d   = wen_q ? 32'd0 : ext_word;
            state_d   = DONE;
          end else begin
            cnt_d              = cnt_inc;
            mem_req_d.Addr     = addr_q + {30'd0, cnt_inc};
            mem_req_d.ByteData = wdata_q[{cnt_inc, 3'b000} +: 8];
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          // This wait cycle brings the count to TIMEOUT: abandon the access.
          tmo_d     = '0;
          mem_req_d = '0;
          done_d    = 1'b1;
          err_d     = 1'b1;
          state_d   = DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      DONE: begin
        mem_req_d = '0;
        state_d   = IDLE;
      end

      default: begin
        mem_req_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      tmo_q     <= '0;
      asm_q     <= 32'd0;
      wen_q     <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      size_q    <= 2'd0;
      uns_q     <= 1'b0;
      mem_req_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      asm_q     <= asm_d;
      wen_q     <= wen_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      mem_req_q <= mem_req_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  // Stall covers the accept cycle and every byte cycle; DONE lets the pipe move.
  assign Stall_o = ((state_q == IDLE) && Req_i) || (state_q == ACCESS);
  assign Done_o  = done_q;
  assign Err_o   = err_q;
  assign RData_o = rdata_q;

  assign mem.MemValid_o = mem_req_q.Valid;
  assign mem.MemWen_o   = mem_req_q.Wen;
  assign mem.MemAddr_o  = mem_req_q.Addr;
  assign mem.MemByte_o  = mem_req_q.ByteData;

endmodule
